// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyph table,
// the all-dark pattern and the {a,b,c,d,e,f,g} bit positions within seg.
package seg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex glyphs 0..F, active-low, bit 6 = segment a
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit multiplexed seven-segment driver with frame-aligned value updates,
// leading-zero blanking, per-digit blank/dp and anode dead-time.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int SLOT_CYCLES = 100000,
    parameter int DEAD_CYCLES = 1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic                  lzb,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [4*N_DIGITS-1:0] pend_value_reg, shadow_value_reg;
    logic [N_DIGITS-1:0]   pend_dp_reg, shadow_dp_reg;
    logic [N_DIGITS-1:0]   pend_blank_reg, shadow_blank_reg;
    logic                  pend_valid_reg;

    logic                  slot_end, frame_end, in_dead, dark_sel;
    logic [N_DIGITS-1:0]   zero_hi, dark, an_next;
    logic [3:0]            nibble;
    logic [6:0]            glyph, seg_next;
    logic                  dp_n_next;

    assign slot_end  = (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (slot_end) begin
            cnt_reg <= '0;
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // A load coinciding with the boundary lands in pending and waits a full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value_reg   <= '0;
            pend_dp_reg      <= '0;
            pend_blank_reg   <= '0;
            pend_valid_reg   <= 1'b0;
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            shadow_blank_reg <= '0;
        end else begin
            if (frame_end && pend_valid_reg) begin
                shadow_value_reg <= pend_value_reg;
                shadow_dp_reg    <= pend_dp_reg;
                shadow_blank_reg <= pend_blank_reg;
                pend_valid_reg   <= 1'b0;
            end
            if (load) begin
                pend_value_reg <= value;
                pend_dp_reg    <= dp;
                pend_blank_reg <= blank;
                pend_valid_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_dark
        assign zero_hi[gi] = (shadow_value_reg[4*N_DIGITS-1:4*gi] == '0);
        if (gi == 0) begin : g_first
            assign dark[gi] = shadow_blank_reg[gi];
        end else begin : g_rest
            assign dark[gi] = shadow_blank_reg[gi] | (lzb & zero_hi[gi]);
        end
    end

    assign nibble   = shadow_value_reg[{idx_reg, 2'b00} +: 4];
    assign dark_sel = dark[idx_reg];
    assign in_dead  = (cnt_reg < CNT_W'(DEAD_CYCLES));

    seg_decode u_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_an
        assign an_next[gi] = !(!dark_sel && !in_dead && (idx_reg == IDX_W'(gi)));
    end

    always_comb begin
        seg_next  = glyph;
        dp_n_next = ~shadow_dp_reg[idx_reg];
        if (dark_sel) begin
            seg_next  = SEG_BLANK;
            dp_n_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp_n       <= dp_n_next;
            an         <= an_next;
            frame_tick <= frame_end && pend_valid_reg;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench: a cycle-level reference pushes the expected display word at
// every clock edge; a negedge checker pops and compares against the DUT pins.
module tb_seg_scan_mux;

    localparam int N    = 4;
    localparam int SLOT = 4;
    localparam int DEAD = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  value = '0;
    logic [3:0]   dp = '0;
    logic [3:0]   blank = '0;
    logic         lzb = 1'b0;
    logic         load = 1'b0;
    logic [6:0]   seg;
    logic         dp_n;
    logic [3:0]   an;
    logic         frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_mux #(
        .N_DIGITS    (N),
        .SLOT_CYCLES (SLOT),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .lzb        (lzb),
        .load       (load),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tbl [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Expected word: {an[3:0], seg[6:0], dp_n, frame_tick}
    logic [12:0] exp_q [$];

    int          m_cnt = 0, m_idx = 0;
    logic [15:0] m_sh_v = '0, m_pd_v = '0;
    logic [3:0]  m_sh_d = '0, m_pd_d = '0, m_sh_b = '0, m_pd_b = '0;
    logic        m_pv = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_idx = 0;
            m_sh_v = '0; m_sh_d = '0; m_sh_b = '0;
            m_pd_v = '0; m_pd_d = '0; m_pd_b = '0;
            m_pv = 1'b0;
            exp_q.delete();
        end else begin
            int         top_nz;
            logic       dk, boundary;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic       e_dpn;
            top_nz = -1;
            for (int i = 0; i < N; i++)
                if (m_sh_v[4*i +: 4] != 4'h0) top_nz = i;
            dk = m_sh_b[m_idx] || (lzb && m_idx > 0 && m_idx > top_nz);
            e_seg = dk ? 7'h7F : glyph_tbl[m_sh_v[4*m_idx +: 4]];
            e_dpn = dk ? 1'b1 : !m_sh_d[m_idx];
            e_an  = 4'hF;
            if (!dk && m_cnt >= DEAD) e_an[m_idx] = 1'b0;
            boundary = (m_cnt == SLOT-1) && (m_idx == N-1);
            exp_q.push_back({e_an, e_seg, e_dpn, boundary && m_pv});
            if (boundary && m_pv) begin
                m_sh_v = m_pd_v; m_sh_d = m_pd_d; m_sh_b = m_pd_b; m_pv = 1'b0;
            end
            if (load) begin
                m_pd_v = value; m_pd_d = dp; m_pd_b = blank; m_pv = 1'b1;
            end
            if (m_cnt == SLOT-1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % N;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            logic [12:0] e;
            e = exp_q.pop_front();
            chk("an",         32'(an),         32'(e[12:9]));
            chk("seg",        32'(seg),        32'(e[8:2]));
            chk("dp_n",       32'(dp_n),       32'(e[1]));
            chk("frame_tick", 32'(frame_tick), 32'(e[0]));
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        @(negedge clk);
        value = v; dp = d; blank = b; load = 1'b1;
        $display("load value=%h dp=%b blank=%b lzb=%b", v, d, b, lzb);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"},   32'(an),         32'hF);
        chk({tag, "_seg"},  32'(seg),        32'h7F);
        chk({tag, "_dp_n"}, 32'(dp_n),       32'h1);
        chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        int guard;
        run(3);
        chk_reset_outputs("rst_init");
        rst_n = 1'b1;
        $display("reset released");
        run(20);

        // Asynchronous reset between edges, in the middle of a slot
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        $display("mid-slot reset applied");
        @(negedge clk);
        rst_n = 1'b1;
        run(10);

        do_load(16'h1234, 4'b0000, 4'b0000);
        run(40);

        // Tear-free update: load while digit 1 is being scanned
        guard = 0;
        while (m_idx != 1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_idx1", 32'(guard < 40), 32'h1);
        do_load(16'hABCD, 4'b0000, 4'b0000);
        run(40);

        lzb = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        run(36);
        do_load(16'h0000, 4'b0000, 4'b0000);
        run(36);
        lzb = 1'b0;

        do_load(16'h1234, 4'b0100, 4'b0001);
        run(36);

        // Load exactly in the frame-boundary cycle
        guard = 0;
        while (!(m_cnt == SLOT-1 && m_idx == N-1) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_boundary", 32'(guard < 40), 32'h1);
        value = 16'h5678; dp = 4'b0000; blank = 4'b0000; load = 1'b1;
        $display("boundary load value=5678");
        @(negedge clk);
        load = 1'b0;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
